sigma_delta_adc_capture: RTL and testbench

- Sits directly downstream of sigma_delta_adc and consumes its decimated adc_output/adc_valid stream.
- Software arms it. It keeps a circular window that includes pre-trigger history, and fires on a rising level crossing or a forced trigger.
- After firing it replays a DEPTH-sample window oldest-first on a valid/ready stream for a UART or logic-analyser dump path.
- Used on bench and in hardware to capture ADC transients around an event.

---
 rtl/sigma_delta_adc_capture.sv | 268 ++++++++++++++++++++++++++
 tb/tb_sigma_delta_adc_capture.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_adc_capture.sv
// sigma_delta_adc_capture
// Captures a DEPTH-sample window of the decimated sigma-delta ADC stream around
// a trigger event and replays it oldest-first on a valid/ready stream.
//
// Ports:
//   clk          - single clock for all logic
//   rst          - asynchronous, active-low reset
//   adc_output   - decimated ADC sample (unsigned), qualified by adc_valid
//   adc_valid    - one-cycle strobe for adc_output
//   arm          - starts a capture; only honoured in IDLE
//   force_trig   - unconditional trigger; only honoured in ARMED
//   trig_level   - rising-crossing threshold
//   out_data     - replayed sample
//   out_valid    - out_data is valid
//   out_ready    - downstream accepts out_data
//   out_last     - marks the final beat of the window
//   busy         - high whenever the block is not IDLE
//   done         - one-cycle pulse after the final handshake
module sigma_delta_adc_capture #(
    parameter int WDTH  = 2,
    parameter int DEPTH = 64,
    parameter int PRE   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WDTH-1:0] adc_output,
    input  logic            adc_valid,
    input  logic            arm,
    input  logic            force_trig,
    input  logic [WDTH-1:0] trig_level,
    output logic [WDTH-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] PRE_C   = CW'(PRE);
    localparam logic [CW-1:0] POST_C  = CW'(DEPTH - PRE);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PRE_A   = AW'(PRE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_DUMP    = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [WDTH-1:0] mem [DEPTH];

    logic [AW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WDTH-1:0] prev_q, prev_d;
    logic            prev_valid_q, prev_valid_d;
    logic            force_pend_q, force_pend_d;
    logic [AW-1:0]   trig_addr_q, trig_addr_d;

    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   issued_q, issued_d;
    logic [WDTH-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            accept_s;
    logic            cross_s;
    logic            trig_s;
    logic            last_hs_s;
    logic            arm_s;
    logic            load_s;
    logic [CW-1:0]   cnt_inc_s;
    logic [WDTH-1:0] rd_word_s;

    assign accept_s  = adc_valid && ((state_q == ST_PREFILL) || (state_q == ST_ARMED) ||
                                     (state_q == ST_POST));
    assign cross_s   = prev_valid_q && (prev_q < trig_level) && (adc_output >= trig_level);
    // A pending force fires on the first sample at or after the cycle it was seen.
    assign trig_s    = (state_q == ST_ARMED) && adc_valid && (cross_s || force_trig || force_pend_q);
    assign last_hs_s = (state_q == ST_DUMP) && out_valid_q && out_ready && out_last_q;
    // The cycle carrying the done pulse is already IDLE but must not re-arm.
    assign arm_s     = arm && !done_q;
    assign cnt_inc_s = cnt_q + ONE_C;
    assign rd_word_s = mem[rd_ptr_q];
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign load_s    = (state_q == ST_DUMP) && (issued_q != DEPTH_C) && (!out_valid_q || out_ready);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_s) state_d = ST_PREFILL;
                else       state_d = ST_IDLE;
            end
            ST_PREFILL: begin
                if (adc_valid && (cnt_inc_s == PRE_C)) state_d = ST_ARMED;
                else                                   state_d = ST_PREFILL;
            end
            ST_ARMED: begin
                if (trig_s) state_d = ST_POST;
                else        state_d = ST_ARMED;
            end
            ST_POST: begin
                if (adc_valid && (cnt_inc_s == POST_C)) state_d = ST_DUMP;
                else                                    state_d = ST_POST;
            end
            ST_DUMP: begin
                if (last_hs_s) state_d = ST_IDLE;
                else           state_d = ST_DUMP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sample memory write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem[wptr_q] <= adc_output;
        end
    end

    // Capture-side next state: write pointer, sample counter, previous sample, trigger address.
    always_comb begin
        wptr_d       = wptr_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        force_pend_d = force_pend_q;
        trig_addr_d  = trig_addr_q;
        if (accept_s) begin
            wptr_d       = wptr_q + ONE_A;
            prev_d       = adc_output;
            prev_valid_d = 1'b1;
        end else begin
            wptr_d = wptr_q;
        end
        case (state_q)
            ST_IDLE: begin
                cnt_d        = {CW{1'b0}};
                prev_valid_d = 1'b0;
                force_pend_d = 1'b0;
            end
            ST_PREFILL: begin
                // The counter restarts at zero on entry to ARMED.
                if (adc_valid) cnt_d = (cnt_inc_s == PRE_C) ? {CW{1'b0}} : cnt_inc_s;
                else           cnt_d = cnt_q;
            end
            ST_ARMED: begin
                if (trig_s) begin
                    cnt_d        = ONE_C;
                    trig_addr_d  = wptr_q;
                    force_pend_d = 1'b0;
                end else if (force_trig) begin
                    force_pend_d = 1'b1;
                end else begin
                    force_pend_d = force_pend_q;
                end
            end
            ST_POST: begin
                if (adc_valid) cnt_d = cnt_inc_s;
                else           cnt_d = cnt_q;
            end
            ST_DUMP: begin
                cnt_d = {CW{1'b0}};
            end
            default: begin
                cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // Capture-side registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q       <= {AW{1'b0}};
            cnt_q        <= {CW{1'b0}};
            prev_q       <= {WDTH{1'b0}};
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            trig_addr_q  <= {AW{1'b0}};
        end else begin
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            force_pend_q <= force_pend_d;
            trig_addr_q  <= trig_addr_d;
        end
    end

    // Replay-side next state and registered outputs.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        issued_d    = issued_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (state_q != ST_DUMP) begin
            // Keep the read pointer parked at the window start so DUMP begins reading at once.
            rd_ptr_d    = trig_addr_q - PRE_A;
            issued_d    = {CW{1'b0}};
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (load_s) begin
            out_data_d  = rd_word_s;
            out_valid_d = 1'b1;
            out_last_d  = (issued_q == LAST_C);
            rd_ptr_d    = rd_ptr_q + ONE_A;
            issued_d    = issued_q + ONE_C;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        done_d = last_hs_s;
        busy_d = (state_d != ST_IDLE);
    end

    // Replay-side registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= {AW{1'b0}};
            issued_q    <= {CW{1'b0}};
            out_data_q  <= {WDTH{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            issued_q    <= issued_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sigma_delta_adc_capture.sv
module tb_sigma_delta_adc_capture;

    localparam int WDTH  = 8;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [WDTH-1:0] adc_output;
    logic            adc_valid;
    logic            arm;
    logic            force_trig;
    logic [WDTH-1:0] trig_level;
    logic [WDTH-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic            done;

    sigma_delta_adc_capture #(.WDTH(WDTH), .DEPTH(DEPTH), .PRE(PRE)) dut (
        .clk(clk), .rst(rst), .adc_output(adc_output), .adc_valid(adc_valid),
        .arm(arm), .force_trig(force_trig), .trig_level(trig_level),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Stimulus description for one capture, and the model's expected window.
    int s [0:255];
    int ns;
    int lvl;
    int force_idx = -1;
    int busy_arm_idx = -1;
    bit arm_with_sample = 1'b0;
    int exp_win [0:DEPTH-1];
    int got [0:DEPTH-1];
    int beat_idx = 0;
    bit dump_en = 1'b0;
    bit bp_mode = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One ADC sample every 4 clocks.
    task automatic feed(input int v, input bit with_arm);
        tick();
        adc_valid  = 1'b1;
        adc_output = 8'(v);
        arm        = with_arm;
        tick();
        adc_valid  = 1'b0;
        arm        = 1'b0;
        tick();
        tick();
    endtask

    // Downstream ready: always 1, or a random 1/0 pattern under backpressure.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: checks every beat against the model window, stall stability,
    // the done pulse and the absence of stray output activity.
    initial begin
        bit last_hs;
        bit hold_pend;
        int hold_data;
        int hold_last;
        last_hs = 1'b0;
        hold_pend = 1'b0;
        hold_data = 0;
        hold_last = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_hs   = 1'b0;
                hold_pend = 1'b0;
            end else begin
                if (last_hs) begin
                    chk("done_pulse", done, 1);
                    chk("busy_after_last", busy, 0);
                    chk("valid_after_last", out_valid, 0);
                    last_hs = 1'b0;
                end else begin
                    chk("done_quiet", done, 0);
                end
                if (hold_pend) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, hold_data);
                    chk("stall_last", out_last, hold_last);
                end
                hold_pend = out_valid && !out_ready;
                hold_data = out_data;
                hold_last = out_last;
                if (!dump_en) begin
                    chk("idle_valid", out_valid, 0);
                end else if (out_valid && out_ready) begin
                    if (beat_idx < DEPTH) begin
                        chk($sformatf("beat%0d_data", beat_idx), out_data, exp_win[beat_idx]);
                        chk($sformatf("beat%0d_last", beat_idx), out_last, int'(beat_idx == DEPTH - 1));
                        got[beat_idx] = out_data;
                        if (beat_idx == DEPTH - 1) last_hs = 1'b1;
                    end else begin
                        chk("extra_beat", beat_idx, DEPTH - 1);
                    end
                    beat_idx++;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        arm = 1'b0;
        adc_valid = 1'b0;
        adc_output = 8'd0;
        force_trig = 1'b0;
        trig_level = 8'd0;
        dump_en = 1'b0;
        repeat (3) tick();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        tick();
    endtask

    // Runs one capture of s[0..] after arm. The model: the trigger is the first sample
    // index i >= PRE that is a rising crossing of lvl or at/after a forced trigger,
    // and the window is the DEPTH samples starting PRE before it.
    task automatic run_capture(input string tag, input int rst_beat);
        int t;
        int n;
        bit seen;
        t = -1;
        for (int i = PRE; i < ns; i++) begin
            if (t < 0) begin
                if (force_idx >= 0 && i >= force_idx) t = i;
                else if (s[i-1] < lvl && s[i] >= lvl) t = i;
            end
        end
        chk({tag, "_model_trigger_found"}, int'(t >= 0), 1);
        if (t < 0) return;
        for (int k = 0; k < DEPTH; k++) exp_win[k] = s[t - PRE + k];
        beat_idx   = 0;
        trig_level = 8'(lvl);
        dump_en    = 1'b1;
        tick();
        arm        = 1'b1;
        adc_valid  = arm_with_sample;
        adc_output = 8'hFF;
        tick();
        arm        = 1'b0;
        adc_valid  = 1'b0;
        for (int i = 0; i <= t + DEPTH - PRE - 1; i++) begin
            if (i == force_idx) begin
                chk({tag, "_still_armed_busy"}, busy, 1);
                chk({tag, "_still_armed_novalid"}, out_valid, 0);
                force_trig = 1'b1;
                tick();
                force_trig = 1'b0;
            end
            feed(s[i], i == busy_arm_idx);
        end
        if (rst_beat >= 0) begin
            n = 0;
            while (beat_idx < rst_beat && n < 500) begin
                @(posedge clk);
                n++;
            end
            chk({tag, "_reach_rst_beat"}, int'(beat_idx >= rst_beat), 1);
            #2;
            chk({tag, "_valid_before_rst"}, out_valid, 1);
            dump_en = 1'b0;
            rst = 1'b0;
            #1;
            chk({tag, "_rst_valid"}, out_valid, 0);
            chk({tag, "_rst_busy"}, busy, 0);
            chk({tag, "_rst_done"}, done, 0);
            chk({tag, "_rst_last"}, out_last, 0);
            repeat (3) tick();
            rst = 1'b1;
            tick();
            chk({tag, "_after_rst_busy"}, busy, 0);
            return;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 500) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_beat_count"}, beat_idx, DEPTH);
        // arm during the done cycle must be ignored
        arm = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
        tick();
        chk({tag, "_arm_in_done_ignored"}, busy, 0);
        dump_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        arm = 1'b0;
        adc_valid = 1'b0;
        adc_output = 8'd0;
        force_trig = 1'b0;
        trig_level = 8'd0;
        do_reset();

        // Ramp with threshold crossing at 10.
        ns = 40;
        for (int i = 0; i < ns; i++) s[i] = i;
        lvl = 10;
        run_capture("ramp", -1);
        chk("ramp_got0", got[0], 6);
        chk("ramp_got4", got[4], 10);
        chk("ramp_got15", got[15], 21);

        // Same ramp under random backpressure.
        bp_mode = 1'b1;
        run_capture("bp", -1);
        bp_mode = 1'b0;
        chk("bp_got0", got[0], 6);
        chk("bp_got4", got[4], 10);
        chk("bp_got15", got[15], 21);

        // Level above threshold without crossing, then force_trig.
        ns = 50;
        for (int i = 0; i < 30; i++) s[i] = 50;
        for (int i = 30; i < ns; i++) s[i] = 60 + (i - 30);
        force_idx = 30;
        run_capture("force", -1);
        force_idx = -1;
        chk("force_got3", got[3], 50);
        chk("force_got4", got[4], 60);
        chk("force_got15", got[15], 71);

        // Crossing during PREFILL ignored.
        ns = 30;
        s[0] = 0; s[1] = 20; s[2] = 0; s[3] = 0; s[4] = 0; s[5] = 20;
        for (int i = 6; i < ns; i++) s[i] = i + 24;
        run_capture("prefill", -1);
        chk("prefill_got0", got[0], 20);
        chk("prefill_got4", got[4], 20);
        chk("prefill_got5", got[5], 30);
        chk("prefill_got15", got[15], 40);

        // arm together with adc_valid: that sample must be dropped.
        s[0] = 0; s[1] = 0; s[2] = 0; s[3] = 20; s[4] = 0; s[5] = 20;
        arm_with_sample = 1'b1;
        run_capture("armdrop", -1);
        arm_with_sample = 1'b0;
        chk("armdrop_got0", got[0], 0);
        chk("armdrop_got2", got[2], 20);
        chk("armdrop_got4", got[4], 20);

        // Pointer wrap: long ramp, trigger at 200.
        ns = 212;
        for (int i = 0; i < ns; i++) s[i] = i;
        lvl = 200;
        run_capture("wrap", -1);
        chk("wrap_got0", got[0], 196);
        chk("wrap_got4", got[4], 200);
        chk("wrap_got15", got[15], 211);

        // arm during POST is ignored; reset during beat 5; then a fresh capture.
        ns = 40;
        for (int i = 0; i < ns; i++) s[i] = i;
        lvl = 10;
        busy_arm_idx = 12;
        run_capture("midrst", 5);
        busy_arm_idx = -1;
        chk("midrst_got4", got[4], 10);
        run_capture("fresh", -1);
        chk("fresh_got0", got[0], 6);
        chk("fresh_got15", got[15], 21);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
